// File: rtl/mul_share_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing arbiter.
// The tag struct is sized for the largest legal requester count so one type serves every build.
package mul_share_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W     = id_width(NUM_REQ_DEF);
  localparam int TAG_ID_W = id_width(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping mod N.
// Emits a one-hot grant, its encoded index and an any-grant flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand     = (int'(ptr_i) + k) % N;
      cand_idx = IW'(cand);
      if (!found && eligible_i[cand_idx]) begin
        found           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined low-word multiplier among NUM_REQ requesters with round-robin issue,
// a tag pipeline tracking in-flight ops, and per-requester response registers with backpressure.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int MUL_LATENCY = 1,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_result,
  output logic                      busy
);

  localparam int IDX_W = id_width(NUM_REQ);

  logic [IDX_W-1:0]          ptr_q, ptr_d, grant_idx;
  logic [NUM_REQ-1:0]        eligible, grant;
  logic                      grant_any;
  logic [NUM_REQ-1:0]        pending_q, pending_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0]         src1_q, src1_d, src2_q, src2_d;
  logic                      busy_q;
  tag_t                      tag_in, tag_out;
  logic [IDX_W-1:0]          out_idx;

  // Stage 0 travels with the issued operands; the remaining MUL_LATENCY stages mirror the cell.
  tag_t tag_q [0:MUL_LATENCY];

  assign eligible = req_valid & ~pending_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (grant_idx),
    .any_o      (grant_any)
  );

  assign tag_out = tag_q[MUL_LATENCY];
  assign out_idx = tag_out.id[IDX_W-1:0];

  always_comb begin
    ptr_d       = ptr_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    tag_in      = '0;
    pending_d   = pending_q & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;

    if (grant_any) begin
      pending_d[grant_idx] = 1'b1;
      ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      src1_d = req_src1[grant_idx*DATA_W +: DATA_W];
      src2_d = req_src2[grant_idx*DATA_W +: DATA_W];
      tag_in.valid = 1'b1;
      tag_in.id    = TAG_ID_W'(grant_idx);
    end

    // A capture never meets a handshake for the same index: rsp_valid is low while in flight.
    if (tag_out.valid) begin
      rsp_valid_d[out_idx] = 1'b1;
      rsp_data_d[out_idx*DATA_W +: DATA_W] = mul_result;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      pending_q   <= '0;
      rsp_valid_q <= '0;
      // NOTE: the response registers are cleared because their contents are visible at the ports.
      rsp_data_q  <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      busy_q      <= 1'b0;
      for (int s = 0; s <= MUL_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      busy_q      <= |pending_d;
      tag_q[0]    <= tag_in;
      for (int s = 1; s <= MUL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_src1  = src1_q;
  assign mul_src2  = src2_q;
  assign busy      = busy_q;

endmodule
